// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced N-to-2**N decoder.
package decoder_pkg;

  // FSM states: outputs dark, a fixed index shown, or a walking one.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // One-hot decode sized for the largest supported address width (N=6).
  // Callers truncate the result to their own output width.
  function automatic logic [63:0] oneHot(input logic [5:0] i_sel);
    return 64'd1 << i_sel;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that sets how many extra cycles each scan index is held.
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_loadVal,
  input  logic               i_countEn,
  output logic               o_zero
);

  logic [DWELL_W-1:0] r_count;

  // A load takes precedence over counting down; the count never goes below zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_countEn && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/decoder_seq_nxm.sv
// Registered N-to-2**N decoder with a direct-decode mode and a walking-one scan mode.
module decoder_seq_nxm
  import decoder_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       a,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    q,
  output logic [N-1:0]       idx,
  output logic               wrap,
  output logic               busy
);

  localparam int OUT_W = 2**N;

  state_t           r_state;
  logic [N-1:0]     r_idx;
  logic [OUT_W-1:0] r_q;
  logic             r_wrap;
  logic             r_busy;

  logic             w_scanCmd;
  logic             w_tmrLoad;
  logic             w_tmrCountEn;
  logic             w_tmrZero;
  logic [N-1:0]     w_idxInc;

  function automatic logic [OUT_W-1:0] decode(input logic [N-1:0] i_sel);
    return OUT_W'(oneHot(6'(i_sel)));
  endfunction

  // The timer reloads on scan entry, on a restart, and whenever an index has run its dwell.
  always_comb begin
    w_scanCmd    = en && (mode == MODE_SCAN);
    w_tmrLoad    = w_scanCmd && ((r_state != SCAN) || load || w_tmrZero);
    w_tmrCountEn = w_scanCmd && (r_state == SCAN) && !load && !w_tmrZero;
    w_idxInc     = r_idx + 1'b1;
  end

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwellTimer (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_load    (w_tmrLoad),
    .i_loadVal (dwell),
    .i_countEn (w_tmrCountEn),
    .o_zero    (w_tmrZero)
  );

  // FSM with registered outputs; priority is enable, then mode, then load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_q     <= '0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (!en) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (mode == MODE_SCAN) begin
      r_state <= SCAN;
      r_busy  <= 1'b1;
      if (load) begin
        r_idx  <= a;
        r_q    <= decode(a);
        r_wrap <= 1'b0;
      end else if (r_state != SCAN) begin
        r_q    <= decode(r_idx);
        r_wrap <= 1'b0;
      end else if (w_tmrZero) begin
        r_idx  <= w_idxInc;
        r_q    <= decode(w_idxInc);
        r_wrap <= (r_idx == {N{1'b1}});
      end else begin
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
      r_busy <= 1'b0;
      if (load) begin
        r_state <= HOLD;
        r_idx   <= a;
        r_q     <= decode(a);
      end else if (r_state == SCAN) begin
        r_state <= HOLD;
        r_q     <= decode(r_idx);
      end
    end
  end

  assign q    = r_q;
  assign idx  = r_idx;
  assign wrap = r_wrap;
  assign busy = r_busy;

endmodule

// File: tb/tb_decoder_seq_nxm.sv
// Self-checking bench for decoder_seq_nxm (N=3, DWELL_W=4) against a cycle-count reference model.
module tb_decoder_seq_nxm;

  localparam int N       = 3;
  localparam int DWELL_W = 4;
  localparam int SIZE    = 2**N;

  logic               clk;
  logic               rst_n;
  logic               tEn;
  logic               tMode;
  logic [N-1:0]       tA;
  logic               tLoad;
  logic [DWELL_W-1:0] tDwell;
  logic [SIZE-1:0]    q;
  logic [N-1:0]       idx;
  logic               wrap;
  logic               busy;

  int numCompared;
  int numMismatched;

  // Reference model: what is shown, whether scanning, and how long the current index has been on screen.
  bit mShow;
  bit mScan;
  int mIdx;
  bit mWrap;
  int mShownCycles;
  int mHoldCycles;

  decoder_seq_nxm #(
    .N       (N),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tEn),
    .mode  (tMode),
    .a     (tA),
    .load  (tLoad),
    .dwell (tDwell),
    .q     (q),
    .idx   (idx),
    .wrap  (wrap),
    .busy  (busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed %0h, required %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mShow        = 1'b0;
    mScan        = 1'b0;
    mIdx         = 0;
    mWrap        = 1'b0;
    mShownCycles = 0;
    mHoldCycles  = 1;
  endtask

  task automatic modelStep(input bit en, input bit mode, input bit load, input int a, input int dwell);
    mWrap = 1'b0;
    if (!en) begin
      mShow = 1'b0;
      mScan = 1'b0;
    end else if (mode) begin
      if (!mScan || load) begin
        if (load) mIdx = a;
        mScan        = 1'b1;
        mShow        = 1'b1;
        mShownCycles = 1;
        mHoldCycles  = dwell + 1;
      end else if (mShownCycles >= mHoldCycles) begin
        if (mIdx == SIZE - 1) mWrap = 1'b1;
        mIdx         = (mIdx + 1) % SIZE;
        mShownCycles = 1;
        mHoldCycles  = dwell + 1;
      end else begin
        mShownCycles++;
      end
    end else begin
      mScan = 1'b0;
      if (load) begin
        mIdx  = a;
        mShow = 1'b1;
      end
    end
  endtask

  task automatic compareModel();
    logic [63:0] expQ;
    expQ = mShow ? (64'd1 << mIdx) : 64'd0;
    checkOutput("q",    64'(q),    expQ);
    checkOutput("idx",  64'(idx),  64'(mIdx));
    checkOutput("wrap", 64'(wrap), 64'(mWrap));
    checkOutput("busy", 64'(busy), 64'(mScan));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare just after the edge.
  task automatic applyStimulus(input bit en, input bit mode, input bit load, input int a, input int dwell);
    tEn    = en;
    tMode  = mode;
    tLoad  = load;
    tA     = N'(a);
    tDwell = DWELL_W'(dwell);
    @(posedge clk);
    modelStep(en, mode, load, a, dwell);
    #1;
    compareModel();
  endtask

  initial begin
    int wrapCount;
    int guard;
    numCompared   = 0;
    numMismatched = 0;
    modelReset();
    rst_n  = 1'b0;
    tEn    = 1'b0;
    tMode  = 1'b0;
    tLoad  = 1'b0;
    tA     = '0;
    tDwell = '0;

    #12;
    checkOutput("reset_q",    64'(q),    64'd0);
    checkOutput("reset_idx",  64'(idx),  64'd0);
    checkOutput("reset_wrap", 64'(wrap), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    #10 rst_n = 1'b1;

    $display("[TB] direct decode");
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("idle_stays_dark", 64'(q), 64'd0);
    applyStimulus(1, 0, 1, 5, 0);
    checkOutput("direct_q5",    64'(q),    64'h20);
    checkOutput("direct_idx5",  64'(idx),  64'd5);
    checkOutput("direct_busy",  64'(busy), 64'd0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("hold_steady",  64'(q),    64'h20);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("disable_q",    64'(q),    64'd0);
    checkOutput("disable_idx",  64'(idx),  64'd5);

    $display("[TB] scan dwell 0 from 6");
    applyStimulus(1, 1, 1, 6, 0);
    checkOutput("scan0_bit6", 64'(q), 64'h40);
    checkOutput("scan0_busy", 64'(busy), 64'd1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("scan0_bit7", 64'(q), 64'h80);
    checkOutput("scan0_wrap_before", 64'(wrap), 64'd0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("scan0_bit0", 64'(q), 64'h01);
    checkOutput("scan0_wrap", 64'(wrap), 64'd1);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("scan0_bit1", 64'(q), 64'h02);
    checkOutput("scan0_wrap_after", 64'(wrap), 64'd0);

    $display("[TB] scan dwell 2 from 0");
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 2);
    checkOutput("scan2_entry_wrap", 64'(wrap), 64'd0);
    wrapCount = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1, 1, 0, 0, 2);
      if (wrap) wrapCount++;
      if (i == 2) checkOutput("scan2_idx_at3", 64'(idx), 64'd1);
    end
    checkOutput("scan2_idx_back0", 64'(idx), 64'd0);
    checkOutput("scan2_wrap_count", 64'(wrapCount), 64'd1);

    $display("[TB] scan freeze at 3");
    guard = 0;
    while (idx != 3'd3 && guard < 40) begin
      applyStimulus(1, 1, 0, 0, 0);
      guard++;
    end
    checkOutput("freeze_reach_timeout", 64'(guard < 40), 64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("freeze_q", 64'(q), 64'h08);
      checkOutput("freeze_busy", 64'(busy), 64'd0);
    end

    $display("[TB] restart at 7");
    applyStimulus(1, 1, 0, 0, 0);
    guard = 0;
    while (idx != 3'd7 && guard < 40) begin
      applyStimulus(1, 1, 0, 0, 0);
      guard++;
    end
    checkOutput("restart_reach_timeout", 64'(guard < 40), 64'd1);
    applyStimulus(1, 1, 1, 2, 0);
    checkOutput("restart_q", 64'(q), 64'h04);
    checkOutput("restart_wrap", 64'(wrap), 64'd0);
    applyStimulus(0, 0, 1, 5, 0);
    checkOutput("disabled_load_q", 64'(q), 64'd0);
    checkOutput("disabled_load_idx", 64'(idx), 64'd2);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("after_disabled_load_q", 64'(q), 64'd0);

    $display("[TB] asynchronous reset mid-scan");
    applyStimulus(1, 1, 1, 6, 0);
    applyStimulus(1, 1, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("areset_q",    64'(q),    64'd0);
    checkOutput("areset_idx",  64'(idx),  64'd0);
    checkOutput("areset_wrap", 64'(wrap), 64'd0);
    checkOutput("areset_busy", 64'(busy), 64'd0);
    modelReset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 3, 0);
      checkOutput("post_reset_dark", 64'(q), 64'd0);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 9) != 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 5) == 0,
                    int'($urandom_range(0, SIZE - 1)),
                    int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/decoder_seq_nxm.md
DECODER_SEQ_NXM -- requirements
Module: decoder_seq_nxm

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the address width; output width is 2**N; legal range is 1..6.
REQ-002 The block SHALL have parameter DWELL_W, default 4, meaning the width of the scan dwell count.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit, the global enable; 0 forces idle.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = direct decode, 1 = scan (walking one).
REQ-007 The block SHALL have port a, input, N bits: the decode address in direct mode and the start index in scan mode.
REQ-008 The block SHALL have port load, input, 1 bit, a strobe that captures a.
REQ-009 The block SHALL have port dwell, input, DWELL_W bits, giving the extra cycles each index is held in scan mode.
REQ-010 The block SHALL have port q, output, 2**N bits, the registered one-hot output.
REQ-011 The block SHALL have port idx, output, N bits, the registered currently selected index.
REQ-012 The block SHALL have port wrap, output, 1 bit, a one-cycle pulse when the scan index wraps from 2**N-1 to 0.
REQ-013 The block SHALL have port busy, output, 1 bit, high while in state SCAN.

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, HOLD and SCAN.
REQ-015 q SHALL equal 1<<idx in HOLD and SCAN, and all zeros in IDLE; q, idx, wrap and busy SHALL be registered with no combinational path from inputs.
REQ-016 Input priority at each edge SHALL be en=0, then mode, then load.
REQ-017 en=0 from any state SHALL go to IDLE on the next edge, with q=0, wrap=0, busy=0, and idx retained.
REQ-018 IDLE with en=1, mode=0, load=1 SHALL go to HOLD with idx<=a; q shows 1<<a one cycle after the load edge (latency 1).
REQ-019 IDLE with en=1, mode=0, load=0 SHALL remain in IDLE.
REQ-020 HOLD with en=1, mode=0, load=1 SHALL update idx<=a and stay in HOLD; with load=0, the block holds q unchanged.
REQ-021 IDLE or HOLD with en=1, mode=1 SHALL go to SCAN; on entry, idx<=a if load=1, otherwise idx is kept; the dwell counter loads dwell.
REQ-022 In SCAN, the dwell counter SHALL decrement each cycle; when it is 0, idx<=idx+1 modulo 2**N and the counter reloads the dwell value sampled on that edge.
REQ-023 With dwell=0, the scan index SHALL advance every cycle, and each index SHALL be displayed for dwell+1 cycles.
REQ-024 wrap SHALL be 1 for exactly the cycle in which idx first shows 0 after 2**N-1; it SHALL NOT assert on SCAN entry at index 0.
REQ-025 load=1 in SCAN with mode=1 SHALL restart the scan at idx<=a, reload the counter, and produce no wrap pulse.
REQ-026 mode=0 in SCAN SHALL go to HOLD, freezing the current idx; if load=1 on the same edge, idx<=a.
REQ-027 An idx increment when N=1 SHALL toggle between 0 and 1, and wrap SHALL pulse on each transition from 1 to 0.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, force state IDLE, idx=0, q=0, wrap=0, busy=0 and dwell counter=0.
REQ-029 Reset asserted mid-scan SHALL abort the scan, and no wrap pulse SHALL follow reset release.
REQ-030 After rst_n rises, the first active edge SHALL evaluate the inputs per REQ-016 to REQ-026.

Structure
REQ-031 The shared package decoder_pkg SHALL hold the FSM state enumeration (IDLE, HOLD, SCAN), the mode constants MODE_DIRECT=0 and MODE_SCAN=1, and a one-hot function.
REQ-032 The dwell counter SHALL be a separate sub-module dwell_timer, parameterised by DWELL_W, with load, count-enable and zero-flag outputs.
REQ-033 The top level SHALL contain only the FSM, the idx register and the output registers.

Verification (N=3, DWELL_W=4)
REQ-034 Direct decode: with en=1, mode=0, pulse load with a=5 -> next cycle q=8'b0010_0000, idx=5, busy=0; then drive en=0 -> next cycle q=0.
REQ-035 Scan with dwell=0: with en=1, mode=1, load=1, a=6 -> q shows bit6, bit7, bit0 (wrap=1 on that cycle only), then bit1, each for one cycle.
REQ-036 Scan with dwell=2: starting at a=0 -> each index is held 3 cycles; idx returns to 0 after 24 cycles with a single wrap pulse; no wrap at the start.
REQ-037 Scan freeze: set mode=0 while idx=3 -> state HOLD, q=8'b0000_1000 held steady, busy=0.
REQ-038 Restart: pulse load with a=2 mid-scan at idx=7 -> next q=bit2 with wrap=0; with en=0 and load=1 on the same edge -> q=0 and the load is ignored.
REQ-039 Asynchronous reset: drive rst_n low between clock edges during scan -> q, idx, wrap and busy are 0 before the next edge, and remain 0 after release until a new load or scan command.
